// File: rtl/serial_paralelo_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx_pkg
//   Definitions shared by the RX serial-to-parallel block and its TX
//   counterpart: the default COM (alignment/idle) character and the link
//   state encoding. The raw code 2'd3 is unused and treated as SEARCH.
// -----------------------------------------------------------------------------
package serial_paralelo_rx_pkg;

  localparam logic [7:0] COM_CHAR_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } link_state_e;

endpackage : serial_paralelo_rx_pkg

// File: rtl/serial_paralelo_rx_shift_reg.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx_shift_reg
//   Serial history register. The stream enters MSB first; nxt_byte_o is the
//   byte completed by the bit presented this cycle, {history, data_i}.
//   Only DATA_W-1 bits of history are kept: the oldest bit of a DATA_W-wide
//   register would be shifted out before it could ever appear in nxt_byte_o.
// Ports
//   clk_i       clock, one serial bit per cycle
//   reset_i     synchronous active-high reset, clears the history
//   data_i      serial input bit
//   nxt_byte_o  byte ending with this cycle's bit
// -----------------------------------------------------------------------------
module serial_paralelo_rx_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              data_i,
  output logic [DATA_W-1:0] nxt_byte_o
);

  logic [DATA_W-2:0] hist_q;

  assign nxt_byte_o = {hist_q, data_i};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= nxt_byte_o[DATA_W-2:0];
    end
  end

endmodule : serial_paralelo_rx_shift_reg

// File: rtl/serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx
//   Receive-side serial-to-parallel converter feeding the L2 demux. Hunts
//   bit-by-bit for COM_CHAR, confirms alignment with COM_COUNT consecutive
//   aligned COMs, then delivers one byte per DATA_W cycles. Idle COMs after
//   lock are reported with valid_out=0; every other byte with valid_out=1.
//   Once ACTIVE the link stays locked until reset (no realignment).
// Ports
//   clk_32f    clock, one serial bit per cycle
//   reset      synchronous active-high reset
//   data_in    serial bit, MSB of each byte first
//   data_out   last deserialized non-COM byte, held between strobes
//   valid_out  1 = data_out is payload; 0 = idle/COM/unlocked
//   byte_stb   one-cycle pulse on each aligned byte boundary while ACTIVE
//   active     link locked
// Handshake: no backpressure. A byte is presented for exactly the cycle in
//   which byte_stb=1; valid_out qualifies it as payload (1) or idle (0).
// -----------------------------------------------------------------------------
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] COM_CHAR  = DATA_W'(COM_CHAR_DEFAULT),
  parameter int                COM_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_stb,
  output logic              active
);

  localparam int                CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam int                CC_W      = $clog2(COM_COUNT + 1);
  localparam logic [CC_W-1:0]   CC_ONE    = CC_W'(1);
  localparam logic [CC_W-1:0]   CC_TARGET = CC_W'(COM_COUNT);

  link_state_e       state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [CC_W-1:0]   com_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              stb_q;

  logic [DATA_W-1:0] nxt_byte;
  logic              boundary;
  logic              is_com;
  logic [CNT_W-1:0]  bit_cnt_inc;

  serial_paralelo_rx_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk_i      (clk_32f),
    .reset_i    (reset),
    .data_i     (data_in),
    .nxt_byte_o (nxt_byte)
  );

  assign boundary    = (bit_cnt_q == LAST_BIT);
  assign is_com      = (nxt_byte == COM_CHAR);
  // Wraps mod DATA_W so the boundary stays aligned for non-power-of-2 widths.
  assign bit_cnt_inc = boundary ? '0 : bit_cnt_q + 1'b1;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          // Phase is meaningless until a COM is seen; the counter free-runs.
          bit_cnt_q <= bit_cnt_inc;
          if (is_com) begin
            bit_cnt_q <= '0;
            com_cnt_q <= CC_ONE;
            state_q   <= (COM_COUNT == 1) ? ACTIVE : LOCK;
          end
        end
        LOCK: begin
          bit_cnt_q <= bit_cnt_inc;
          if (boundary) begin
            if (is_com) begin
              if (com_cnt_q != CC_TARGET) com_cnt_q <= com_cnt_q + CC_ONE;
              if (com_cnt_q + CC_ONE == CC_TARGET) state_q <= ACTIVE;
            end else begin
              // Any non-COM at an aligned boundary restarts the hunt.
              state_q   <= SEARCH;
              com_cnt_q <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt_q <= bit_cnt_inc;
          if (boundary) begin
            stb_q <= 1'b1;
            if (is_com) begin
              valid_q <= 1'b0;
            end else begin
              data_q  <= nxt_byte;
              valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= SEARCH;
          com_cnt_q <= '0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign byte_stb  = stb_q;
  assign active    = (state_q == ACTIVE);

endmodule : serial_paralelo_rx

// File: tb/tb_serial_paralelo_rx.sv
module tb_serial_paralelo_rx;

  localparam int         DATA_W    = 8;
  localparam int         COM_COUNT = 4;
  localparam logic [7:0] COM       = 8'hBC;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;

  always #5 clk = ~clk;

  serial_paralelo_rx #(
    .DATA_W    (DATA_W),
    .COM_CHAR  (COM),
    .COM_COUNT (COM_COUNT)
  ) dut (
    .clk_32f   (clk),
    .reset     (rst),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_stb  (byte_stb),
    .active    (active)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Link mode: 0 hunting, 1 counting aligned COMs, 2 locked.
  // m_bits counts bits received since the aligning COM; a byte boundary is
  // every 8th bit after it.
  int         m_mode  = 0;
  int         m_bits  = 0;
  int         m_coms  = 0;
  logic [7:0] m_last8 = 8'h00;
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_stb   = 1'b0;

  task automatic model_update(input logic b, input logic r);
    logic [7:0] byte_now;
    if (r) begin
      m_mode = 0; m_bits = 0; m_coms = 0; m_last8 = 8'h00;
      m_data = 8'h00; m_valid = 1'b0; m_stb = 1'b0;
      return;
    end
    byte_now = {m_last8[6:0], b};
    m_stb    = 1'b0;
    if (m_mode == 0) begin
      if (byte_now == COM) begin
        m_bits = 0;
        m_coms = 1;
        m_mode = (COM_COUNT == 1) ? 2 : 1;
      end
    end else begin
      m_bits = m_bits + 1;
      if (m_bits % DATA_W == 0) begin
        if (m_mode == 1) begin
          if (byte_now == COM) begin
            m_coms = m_coms + 1;
            if (m_coms >= COM_COUNT) m_mode = 2;
          end else begin
            m_mode = 0;
            m_coms = 0;
          end
        end else begin
          m_stb = 1'b1;
          if (byte_now == COM) m_valid = 1'b0;
          else begin
            m_data  = byte_now;
            m_valid = 1'b1;
          end
        end
      end
    end
    m_last8 = byte_now;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic b);
    @(negedge clk);
    data_in = b;
    @(posedge clk);
    model_update(b, rst);
    #1;
    check("cyc_data_out",  {24'h0, data_out}, {24'h0, m_data});
    check("cyc_valid_out", {31'h0, valid_out}, {31'h0, m_valid});
    check("cyc_byte_stb",  {31'h0, byte_stb}, {31'h0, m_stb});
    check("cyc_active",    {31'h0, active}, {31'h0, (m_mode == 2)});
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) step(b[i]);
  endtask

  task automatic send_random_bits(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)));
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d, input logic v,
                               input logic s, input logic a);
    check({tag, "_data"},   {24'h0, data_out}, {24'h0, d});
    check({tag, "_valid"},  {31'h0, valid_out}, {31'h0, v});
    check({tag, "_stb"},    {31'h0, byte_stb}, {31'h0, s});
    check({tag, "_active"}, {31'h0, active}, {31'h0, a});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] rb;
    int         tok;

    // 1: reset with random serial data
    rst = 1'b1;
    send_random_bits(3);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // 2: four COMs lock the link, then payload
    for (int k = 0; k < 3; k++) send_byte(COM);
    check("pre_lock_active", {31'h0, active}, 32'h0);
    send_byte(COM);
    check_outputs("lock", 8'h00, 1'b0, 1'b0, 1'b1);
    send_byte(8'hA5);
    check_outputs("pay_a5", 8'hA5, 1'b1, 1'b1, 1'b1);
    step(1'b0);
    check("stb_low_after_pulse", {31'h0, byte_stb}, 32'h0);
    for (int i = 6; i >= 0; i--) step(1'(8'h3C >> i));
    check_outputs("pay_3c", 8'h3C, 1'b1, 1'b1, 1'b1);

    // 5: idle COM between payload bytes
    send_byte(8'h11);
    check_outputs("pay_11", 8'h11, 1'b1, 1'b1, 1'b1);
    send_byte(COM);
    check_outputs("idle_com", 8'h11, 1'b0, 1'b1, 1'b1);
    send_byte(8'h22);
    check_outputs("pay_22", 8'h22, 1'b1, 1'b1, 1'b1);

    // random payload while locked (false COM matches must be ignored)
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb);
      check("rand_pay_data", {24'h0, data_out}, {24'h0, (rb == COM) ? m_data : rb});
    end

    // 3: misaligned start, lock still lands on the COM boundary
    rst = 1'b1;
    step(1'($urandom_range(0, 1)));
    rst = 1'b0;
    send_random_bits(3);
    for (int k = 0; k < 4; k++) send_byte(COM);
    check("offset_lock_active", {31'h0, active}, 32'h1);
    send_byte(8'h5A);
    check_outputs("offset_pay", 8'h5A, 1'b1, 1'b1, 1'b1);

    // 4: broken COM run returns to the hunt
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    send_byte(COM);
    send_byte(COM);
    send_byte(8'h00);
    check("broken_run_active", {31'h0, active}, 32'h0);
    for (int k = 0; k < 3; k++) send_byte(COM);
    check("three_com_active", {31'h0, active}, 32'h0);
    send_byte(COM);
    check("relock_active", {31'h0, active}, 32'h1);

    // 6: reset mid-byte while locked
    send_random_bits(3);
    rst = 1'b1;
    step(1'($urandom_range(0, 1)));
    rst = 1'b0;
    check_outputs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(COM);
    check("post_reset_3com", {31'h0, active}, 32'h0);
    send_byte(COM);
    check("post_reset_lock", {31'h0, active}, 32'h1);

    // random token stream from reset: COMs, random bytes and bit slips
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tok = int'($urandom_range(0, 99));
      if (tok < 60)      send_byte(COM);
      else if (tok < 85) send_byte(8'($urandom_range(0, 255)));
      else               step(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_serial_paralelo_rx
